mux_scan_sequencer: RTL

Sequencer that sits directly upstream of the 4-to-1 mux (`mux_4x1`) and consumes its result. It drives the mux's 2-bit select lines through channels 0..3 and waits a programmable settle time on each channel. It then samples the mux output `y` and packs the four samples into a 4-bit snapshot word. The word is offered downstream on a valid/ready handshake, either once per `start` pulse or continuously.

---
 rtl/mux_scan_sequencer_if.sv | 43 ++++
 rtl/mux_scan_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if
//   Bundles the signals between the scan sequencer, the 4-to-1 mux it steers,
//   and the downstream consumer of the snapshot words.
//
//   Handshake: a word transfers on any rising clk edge where valid && ready.
//   While valid is high, data is held stable and valid stays high until that
//   transfer. ready may be high before valid appears.
//
//   Signals:
//     start       begin a scan (honoured only when idle)
//     continuous  restart a scan automatically after each transfer
//     y           mux output being sampled
//     select      mux select lines (channel 0..3)
//     busy        sequencer is not idle
//     data        4-bit snapshot word, bit n = sample of channel n
//     valid       data is valid
//     ready       consumer accepts data
//     fsm_state   current sequencer state, for observation only
//
//   Modports:
//     master  the sequencer side
//     slave   the environment side (mux + consumer + controller)
interface mux_scan_sequencer_if;
    logic       start;
    logic       continuous;
    logic       y;
    logic       ready;
    logic [1:0] select;
    logic       busy;
    logic [3:0] data;
    logic       valid;
    logic [1:0] fsm_state;

    modport master (
        input  start, continuous, y, ready,
        output select, busy, data, valid, fsm_state
    );

    modport slave (
        output start, continuous, y, ready,
        input  select, busy, data, valid, fsm_state
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Steps a 4-to-1 mux through channels 0..3, holds each channel for SETTLE
//   cycles, samples the mux output at the end of each hold and packs the four
//   samples into a 4-bit word offered on a valid/ready handshake. Runs once
//   per start pulse, or back to back while continuous is high.
//
//   Parameters:
//     SETTLE  cycles each channel is held before sampling (1..15)
//
//   Ports:
//     clk     rising-edge clock
//     rst_n   synchronous active-low reset
//     bus     mux_scan_sequencer_if.master (start, continuous, y, ready in;
//             select, busy, data, valid, fsm_state out)
//
//   Optional feature (macro MUX_SCAN_CHANGE_ONLY_EN):
//     In continuous mode a completed word equal to the last transferred word
//     is dropped and the next scan starts immediately. The first word after
//     reset and single-shot words are always delivered.
module mux_scan_sequencer #(
    parameter int SETTLE = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    mux_scan_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] cnt;
    // Channel 3 is never stored here: its sample goes straight into data.
    logic [2:0] acc;
    logic [1:0] select_q;
    logic [3:0] data_q;
    logic       valid_q;
    logic       busy_q;
    logic [3:0] word;
    logic       drop;

    assign word = {bus.y, acc};

`ifdef MUX_SCAN_CHANGE_ONLY_EN
    logic [3:0] last_word;
    logic       have_last;

    assign drop = bus.continuous && have_last && (word == last_word);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_word <= 4'd0;
            have_last <= 1'b0;
        end else if (state == HOLD && bus.ready) begin
            last_word <= data_q;
            have_last <= 1'b1;
        end
    end
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            acc      <= 3'd0;
            select_q <= 2'd0;
            data_q   <= 4'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        select_q <= 2'd0;
                        cnt      <= 4'd0;
                        busy_q   <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        case (select_q)
                            2'd0:    acc[0] <= bus.y;
                            2'd1:    acc[1] <= bus.y;
                            2'd2:    acc[2] <= bus.y;
                            default: ;
                        endcase
                        if (select_q != 2'd3) begin
                            select_q <= select_q + 2'd1;
                            cnt      <= 4'd0;
                        end else if (drop) begin
                            // Unchanged word: start over without offering it.
                            select_q <= 2'd0;
                            cnt      <= 4'd0;
                        end else begin
                            data_q  <= word;
                            valid_q <= 1'b1;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.ready) begin
                        valid_q <= 1'b0;
                        if (bus.continuous) begin
                            select_q <= 2'd0;
                            cnt      <= 4'd0;
                            state    <= SCAN;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.select    = select_q;
    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.fsm_state = state;

endmodule
